wbm_sdram_tester: RTL

WBM_SDRAM_TESTER -- requirements
Module: wbm_sdram_tester

---
 rtl/sdram_tb_pkg.sv | 23 ++
 rtl/wbm_pattern_gen.sv | 39 +++
 rtl/wbm_sdram_tester.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sdram_tb_pkg.sv
// Shared definitions for the Wishbone SDRAM tester: FSM state encoding,
// data-pattern mode codes and the seed width.
package sdram_tb_pkg;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_IDLE     = 3'd1,
      S_WR       = 3'd2,
      S_WR_DRAIN = 3'd3,
      S_GAP      = 3'd4,
      S_RD       = 3'd5,
      S_RD_DRAIN = 3'd6,
      S_DONE     = 3'd7
   } tester_state_t;

   localparam logic [1:0] MODE_INC  = 2'd0;
   localparam logic [1:0] MODE_INV  = 2'd1;
   localparam logic [1:0] MODE_WALK = 2'd2;
   localparam logic [1:0] MODE_LFSR = 2'd3;

   localparam int SEED_W = 16;

endpackage

// File: rtl/wbm_pattern_gen.sv
// Combinational data pattern for a given word address and pass seed.
// Used once to generate write data and once to predict read data.
module wbm_pattern_gen
   import sdram_tb_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 24
) (
   input  logic [AW-1:0]     addr,
   input  logic [SEED_W-1:0] seed,
   input  logic [1:0]        mode,
   output logic [DW-1:0]     data
);

   logic [31:0]   a32;
   logic [31:0]   pos;
   logic [15:0]   x;
   logic [15:0]   f;
   logic [DW-1:0] sum;

   assign a32 = 32'(addr);
   assign sum = a32[DW-1:0] + DW'(seed);
   assign pos = (a32 + 32'(seed)) % 32'(DW);
   // Fold the address to 16 bits, mix in the seed, then take one LFSR step.
   assign x   = a32[15:0] ^ a32[31:16] ^ seed;
   assign f   = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};

   always_comb begin
      data = sum;
      case (mode)
         MODE_INC:  data = sum;
         MODE_INV:  data = ~sum;
         MODE_WALK: data = DW'(1) << pos;
         MODE_LFSR: for (int i = 0; i < DW; i++) data[i] = f[4'(i)];
         default:   data = sum;
      endcase
   end

endmodule

// File: rtl/wbm_sdram_tester.sv
// Wishbone pipelined master that writes a pattern over an address range,
// reads it back in order and counts mismatches; optional looping passes.
module wbm_sdram_tester
   import sdram_tb_pkg::*;
#(
   parameter int DW        = 16,
   parameter int AW        = 24,
   parameter int CMDS_N    = 1024,
   parameter int MAX_OUTST = 8,
   parameter int GAP_N     = 1000,
   parameter int INIT_WAIT = 100000,
   parameter int TIMEOUT_N = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          loop,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] base_addr,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [15:0]   err_cnt,
   output logic [AW-1:0] first_err_addr,
   output logic [DW-1:0] first_err_data,
   output logic [AW-1:0] wbm_adr,
   output logic [DW-1:0] wbm_dat_o,
   input  logic [DW-1:0] wbm_dat_i,
   output logic          wbm_stb,
   output logic          wbm_cyc,
   output logic          wbm_we,
   input  logic          wbm_ack,
   input  logic          wbm_stall,
   output logic [2:0]    state_dbg
);

   // Handshake: a command transfers on a cycle with wbm_stb=1 and wbm_stall=0;
   // acks return one per cycle in issue order while wbm_cyc is held.

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = $clog2(CMDS_N + 1);
   localparam int TW = $clog2(TIMEOUT_N + 1);

   tester_state_t     state, state_nxt;
   logic [31:0]       wait_cnt;
   logic [CW-1:0]     issue_cnt;
   logic [OW-1:0]     outst;
   logic [TW-1:0]     to_cnt;
   logic [AW-1:0]     adr, ack_addr;
   logic [SEED_W-1:0] seed;
   logic              gap_to_rd, first_seen;
   logic [DW-1:0]     wr_pat, chk_pat;
   logic              bus_st, issue, ack_v, last_issue, to_fire;

   assign bus_st     = state inside {S_WR, S_WR_DRAIN, S_RD, S_RD_DRAIN};
   assign wbm_cyc    = bus_st;
   assign wbm_stb    = (state == S_WR || state == S_RD) && (outst != OW'(MAX_OUTST));
   assign wbm_we     = (state == S_WR || state == S_WR_DRAIN);
   assign wbm_adr    = bus_st ? adr : '0;
   assign wbm_dat_o  = (state == S_WR) ? wr_pat : '0;
   assign issue      = wbm_stb && !wbm_stall;
   // Stray acks with nothing outstanding are dropped here.
   assign ack_v      = wbm_ack && bus_st && (outst != '0);
   assign last_issue = issue && (issue_cnt == CW'(CMDS_N - 1));
   assign to_fire    = (outst != '0) && !ack_v && (to_cnt == TW'(TIMEOUT_N - 1));
   assign busy       = !(state == S_INIT || state == S_IDLE);
   assign done       = (state == S_DONE);
   assign state_dbg  = state;

   wbm_pattern_gen #(.DW(DW), .AW(AW)) u_wr_pat (
      .addr(adr), .seed(seed), .mode(mode), .data(wr_pat)
   );

   wbm_pattern_gen #(.DW(DW), .AW(AW)) u_chk_pat (
      .addr(ack_addr), .seed(seed), .mode(mode), .data(chk_pat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:     if (wait_cnt == 32'(INIT_WAIT - 1)) state_nxt = S_IDLE;
         S_IDLE:     if (start) state_nxt = S_WR;
         S_WR:       if (to_fire) state_nxt = S_DONE;
                     else if (last_issue) state_nxt = S_WR_DRAIN;
         S_WR_DRAIN: if (to_fire) state_nxt = S_DONE;
                     else if (outst == '0) state_nxt = S_GAP;
         S_GAP:      if (wait_cnt == 32'(GAP_N - 1)) state_nxt = gap_to_rd ? S_RD : S_WR;
         S_RD:       if (to_fire) state_nxt = S_DONE;
                     else if (last_issue) state_nxt = S_RD_DRAIN;
         S_RD_DRAIN: if (to_fire) state_nxt = S_DONE;
                     else if (outst == '0) state_nxt = loop ? S_GAP : S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt       <= '0;
         issue_cnt      <= '0;
         outst          <= '0;
         to_cnt         <= '0;
         adr            <= '0;
         ack_addr       <= '0;
         seed           <= '0;
         gap_to_rd      <= 1'b0;
         first_seen     <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
         timeout        <= 1'b0;
      end else begin
         if (state_nxt != state) wait_cnt <= '0;
         else if (state == S_INIT || state == S_GAP) wait_cnt <= wait_cnt + 32'd1;

         // Outside a bus phase, address pointers are parked at base_addr so
         // every pass starts there; any abandoned commands are forgotten.
         if (!bus_st) begin
            issue_cnt <= '0;
            adr       <= base_addr;
            ack_addr  <= base_addr;
            outst     <= '0;
            to_cnt    <= '0;
         end else begin
            if (issue) begin
               adr       <= adr + AW'(1);
               issue_cnt <= issue_cnt + CW'(1);
            end
            if (ack_v) ack_addr <= ack_addr + AW'(1);
            if (issue && !ack_v)      outst <= outst + OW'(1);
            else if (!issue && ack_v) outst <= outst - OW'(1);
            if (outst == '0 || ack_v) to_cnt <= '0;
            else if (!to_fire)        to_cnt <= to_cnt + TW'(1);
         end

         if (state == S_IDLE && start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_seen     <= 1'b0;
            timeout        <= 1'b0;
            seed           <= '0;
            gap_to_rd      <= 1'b0;
         end

         if (ack_v && (state == S_RD || state == S_RD_DRAIN) && (wbm_dat_i != chk_pat)) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (!first_seen) begin
               first_seen     <= 1'b1;
               first_err_addr <= ack_addr;
               first_err_data <= wbm_dat_i;
            end
         end

         if (state == S_WR_DRAIN && state_nxt == S_GAP) gap_to_rd <= 1'b1;
         if (state == S_RD_DRAIN && state_nxt == S_GAP) begin
            gap_to_rd <= 1'b0;
            seed      <= seed + SEED_W'(1);
         end
         if (to_fire) timeout <= 1'b1;
      end
   end

endmodule
